// File: rtl/product_accumulator_if.sv
// product_accumulator_if: handshake bundle between the multiplier side,
// the product accumulator and its result consumer.
// master: the environment (drives products, accepts results).
// slave:  the accumulator itself.
interface product_accumulator_if #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_product;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic              out_overflow;

    modport master (
        output in_valid,
        output in_product,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum,
        input  out_overflow
    );

    modport slave (
        input  in_valid,
        input  in_product,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum,
        output out_overflow
    );
endinterface

// File: rtl/product_accumulator.sv
// product_accumulator: sums COUNT consecutive unsigned products into one
// ACC_W-bit result with valid/ready handshakes on both sides.
// A result is held in HOLD until the consumer takes it; no product is
// accepted while a result is pending. clear aborts everything synchronously.
// Optional build macro ACC_SATURATE_EN: on carry out the accumulator clamps
// to all-ones for the rest of the result instead of wrapping.
module product_accumulator #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 16,
    parameter int COUNT  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    product_accumulator_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [7:0] COUNT_C = 8'(COUNT);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    logic               in_ready_c;
    logic               accept;
    logic [PROD_W-1:0]  prod_in;
    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W:0]     sum_wide;
    logic               carry;
    logic [ACC_W-1:0]   acc_add;
    logic [7:0]         cnt_inc;

    assign prod_in = bus.in_product;

    // Ready is withheld during reset, during clear and while a result is held.
    always_comb begin
        in_ready_c = rst_n && !clear && (state_q != HOLD);
        accept     = bus.in_valid && in_ready_c;
    end

    // One wide add gives both the next partial sum and its carry out.
    always_comb begin
        prod_ext = ACC_W'(prod_in);
        sum_wide = {1'b0, acc_q} + {1'b0, prod_ext};
        carry    = sum_wide[ACC_W];
        cnt_inc  = cnt_q + 8'd1;
`ifdef ACC_SATURATE_EN
        acc_add  = (carry || ovf_q) ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
        acc_add  = sum_wide[ACC_W-1:0];
`endif
    end

    // Next-state logic: clear wins over every handshake.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        acc_d   = prod_ext;
                        cnt_d   = 8'd1;
                        ovf_d   = 1'b0;
                        state_d = (COUNT_C == 8'd1) ? HOLD : ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc_d = acc_add;
                        cnt_d = cnt_inc;
                        ovf_d = ovf_q | carry;
                        if (cnt_inc == COUNT_C) begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state_d = IDLE;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            endcase
        end
    end

    // State, accumulator, counter and overflow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // The accumulator register doubles as the result register, so the
    // result is stable for the whole HOLD state.
    assign bus.in_ready     = in_ready_c;
    assign bus.out_valid    = (state_q == HOLD);
    assign bus.out_sum      = acc_q;
    assign bus.out_overflow = ovf_q;

endmodule
